// File: rtl/udp_frame_tx_if.sv
// Header descriptor, payload stream and frame stream bundle for udp_frame_tx.
interface udp_frame_tx_if;
  // Header descriptor channel
  logic        s_udp_hdr_valid;
  logic        s_udp_hdr_ready;
  logic [47:0] s_eth_dest_mac;
  logic [47:0] s_eth_src_mac;
  logic [31:0] s_ip_source_ip;
  logic [31:0] s_ip_dest_ip;
  logic [15:0] s_udp_source_port;
  logic [15:0] s_udp_dest_port;
  logic [15:0] s_udp_length;
  // Payload byte stream
  logic [7:0]  s_udp_payload_axis_tdata;
  logic        s_udp_payload_axis_tvalid;
  logic        s_udp_payload_axis_tready;
  logic        s_udp_payload_axis_tlast;
  logic        s_udp_payload_axis_tuser;
  // Frame byte stream toward the MAC
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  // Status
  logic        busy;
  logic        error_payload_length;

  // Frame builder side
  modport master (
    input  s_udp_hdr_valid, s_eth_dest_mac, s_eth_src_mac, s_ip_source_ip, s_ip_dest_ip,
    input  s_udp_source_port, s_udp_dest_port, s_udp_length,
    output s_udp_hdr_ready,
    input  s_udp_payload_axis_tdata, s_udp_payload_axis_tvalid,
    input  s_udp_payload_axis_tlast, s_udp_payload_axis_tuser,
    output s_udp_payload_axis_tready,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
    input  m_axis_tready,
    output busy, error_payload_length
  );

  // Application / MAC side
  modport slave (
    output s_udp_hdr_valid, s_eth_dest_mac, s_eth_src_mac, s_ip_source_ip, s_ip_dest_ip,
    output s_udp_source_port, s_udp_dest_port, s_udp_length,
    input  s_udp_hdr_ready,
    output s_udp_payload_axis_tdata, s_udp_payload_axis_tvalid,
    output s_udp_payload_axis_tlast, s_udp_payload_axis_tuser,
    input  s_udp_payload_axis_tready,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
    output m_axis_tready,
    input  busy, error_payload_length
  );
endinterface

// File: rtl/udp_frame_tx.sv
// Builds an Ethernet II / IPv4 / UDP frame from a header descriptor and a payload stream.
module udp_frame_tx #(
  parameter logic [7:0] IP_TTL  = 8'd64,
  parameter logic [5:0] IP_DSCP = 6'd0
) (
  input  logic          logic_clk,
  input  logic          logic_rst_n,
  udp_frame_tx_if.master bus
);

  localparam int unsigned HDR_BYTES = 42;
  localparam int unsigned CK_WORDS  = 10;
  localparam logic [5:0]  LAST_HDR  = 6'(HDR_BYTES - 1);
  localparam logic [3:0]  CK_DONE   = 4'(CK_WORDS);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_HEADER  = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [47:0] r_dest_mac;
  logic [47:0] r_src_mac;
  logic [31:0] r_src_ip;
  logic [31:0] r_dst_ip;
  logic [15:0] r_src_port;
  logic [15:0] r_dst_port;
  logic [15:0] r_udp_len;
  logic [15:0] r_ident;
  logic [15:0] r_ident_lat;
  logic [5:0]  r_byte_cnt;
  logic [15:0] r_ck_acc;
  logic [3:0]  r_ck_idx;
  logic [15:0] r_pay_cnt;

  logic        w_hdr_acc;
  logic        w_len_short;
  logic        w_cnt_mis;
  logic [15:0] w_total_len;
  logic [15:0] w_ck_word;
  logic [HDR_BYTES-1:0][7:0] w_hdr_bytes;

  logic        w_hdr_ready;
  logic [7:0]  w_m_tdata;
  logic        w_m_tvalid;
  logic        w_m_tlast;
  logic        w_m_tuser;
  logic        w_pay_tready;
  logic        w_err;

  // 16-bit ones' complement addition with end-around carry
  function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + 16'(s[16]);
  endfunction

  assign w_hdr_acc   = bus.s_udp_hdr_valid && (r_state == ST_IDLE);
  assign w_len_short = bus.s_udp_length < 16'd8;
  assign w_total_len = r_udp_len + 16'd20;
  assign w_cnt_mis   = (r_pay_cnt + 16'd1) != (r_udp_len - 16'd8);

  // Whole header laid out MSB first; byte 0 sits in the top slot
  assign w_hdr_bytes = {r_dest_mac, r_src_mac, 16'h0800, 8'h45, IP_DSCP, 2'b00, w_total_len,
                        r_ident_lat, 16'h4000, IP_TTL, 8'h11, ~r_ck_acc, r_src_ip, r_dst_ip,
                        r_src_port, r_dst_port, r_udp_len, 16'h0000};

  // IPv4 header word fed to the serial checksum, checksum field itself taken as zero
  always_comb begin
    w_ck_word = 16'h0000;
    case (r_ck_idx)
      4'd0:    w_ck_word = {8'h45, IP_DSCP, 2'b00};
      4'd1:    w_ck_word = w_total_len;
      4'd2:    w_ck_word = r_ident_lat;
      4'd3:    w_ck_word = 16'h4000;
      4'd4:    w_ck_word = {IP_TTL, 8'h11};
      4'd6:    w_ck_word = r_src_ip[31:16];
      4'd7:    w_ck_word = r_src_ip[15:0];
      4'd8:    w_ck_word = r_dst_ip[31:16];
      4'd9:    w_ck_word = r_dst_ip[15:0];
      default: w_ck_word = 16'h0000;
    endcase
  end

  // State register
  always_ff @(posedge logic_clk or negedge logic_rst_n) begin
    if (!logic_rst_n) r_state <= ST_IDLE;
    else              r_state <= w_state_nxt;
  end

  // Next state and stream outputs; payload phase is a straight pass-through
  always_comb begin
    w_state_nxt  = r_state;
    w_hdr_ready  = 1'b0;
    w_m_tdata    = 8'h00;
    w_m_tvalid   = 1'b0;
    w_m_tlast    = 1'b0;
    w_m_tuser    = 1'b0;
    w_pay_tready = 1'b0;
    w_err        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_hdr_ready = 1'b1;
        if (bus.s_udp_hdr_valid) begin
          w_state_nxt = ST_HEADER;
          w_err       = w_len_short;
        end
      end
      ST_HEADER: begin
        w_m_tvalid = 1'b1;
        w_m_tdata  = w_hdr_bytes[LAST_HDR - r_byte_cnt];
        if (r_byte_cnt == LAST_HDR) begin
          w_m_tlast = (r_udp_len == 16'd8);
          if (bus.m_axis_tready)
            w_state_nxt = (r_udp_len == 16'd8) ? ST_IDLE : ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        w_m_tdata    = bus.s_udp_payload_axis_tdata;
        w_m_tvalid   = bus.s_udp_payload_axis_tvalid;
        w_m_tlast    = bus.s_udp_payload_axis_tlast;
        w_m_tuser    = bus.s_udp_payload_axis_tlast & (bus.s_udp_payload_axis_tuser | w_cnt_mis);
        w_pay_tready = bus.m_axis_tready;
        if (bus.s_udp_payload_axis_tvalid && bus.m_axis_tready && bus.s_udp_payload_axis_tlast) begin
          w_state_nxt = ST_IDLE;
          w_err       = w_cnt_mis;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Descriptor capture, header byte pointer, serial checksum and payload counter
  always_ff @(posedge logic_clk or negedge logic_rst_n) begin
    if (!logic_rst_n) begin
      r_dest_mac  <= '0;
      r_src_mac   <= '0;
      r_src_ip    <= '0;
      r_dst_ip    <= '0;
      r_src_port  <= '0;
      r_dst_port  <= '0;
      r_udp_len   <= '0;
      r_ident     <= '0;
      r_ident_lat <= '0;
      r_byte_cnt  <= '0;
      r_ck_acc    <= '0;
      r_ck_idx    <= '0;
      r_pay_cnt   <= '0;
    end else if (w_hdr_acc) begin
      r_dest_mac  <= bus.s_eth_dest_mac;
      r_src_mac   <= bus.s_eth_src_mac;
      r_src_ip    <= bus.s_ip_source_ip;
      r_dst_ip    <= bus.s_ip_dest_ip;
      r_src_port  <= bus.s_udp_source_port;
      r_dst_port  <= bus.s_udp_dest_port;
      r_udp_len   <= w_len_short ? 16'd8 : bus.s_udp_length;
      r_ident_lat <= r_ident;
      r_ident     <= r_ident + 16'd1;
      r_byte_cnt  <= '0;
      r_ck_acc    <= '0;
      r_ck_idx    <= '0;
      r_pay_cnt   <= '0;
    end else if (r_state == ST_HEADER) begin
      if (bus.m_axis_tready && (r_byte_cnt != LAST_HDR))
        r_byte_cnt <= r_byte_cnt + 6'd1;
      if (r_ck_idx != CK_DONE) begin
        r_ck_acc <= ones_add(r_ck_acc, w_ck_word);
        r_ck_idx <= r_ck_idx + 4'd1;
      end
    end else if (r_state == ST_PAYLOAD) begin
      if (bus.s_udp_payload_axis_tvalid && bus.m_axis_tready)
        r_pay_cnt <= r_pay_cnt + 16'd1;
    end
  end

  assign bus.s_udp_hdr_ready           = w_hdr_ready;
  assign bus.s_udp_payload_axis_tready = w_pay_tready;
  assign bus.m_axis_tdata              = w_m_tdata;
  assign bus.m_axis_tvalid             = w_m_tvalid;
  assign bus.m_axis_tlast              = w_m_tlast;
  assign bus.m_axis_tuser              = w_m_tuser;
  assign bus.busy                      = (r_state != ST_IDLE);
  assign bus.error_payload_length      = w_err;

endmodule

// File: tb/tb_udp_frame_tx.sv
// Scoreboard bench for udp_frame_tx: model pushes expected frame beats, monitor pops and compares.
module tb_udp_frame_tx;

  localparam logic [7:0] TTL  = 8'd64;
  localparam logic [5:0] DSCP = 6'd0;

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

  typedef struct {
    logic [47:0] dmac;
    logic [47:0] smac;
    logic [31:0] sip;
    logic [31:0] dip;
    logic [15:0] sport;
    logic [15:0] dport;
    logic [15:0] len;
  } hdr_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  udp_frame_tx_if ifc();

  udp_frame_tx #(.IP_TTL(TTL), .IP_DSCP(DSCP)) dut (
    .logic_clk  (clk),
    .logic_rst_n(rst_n),
    .bus        (ifc)
  );

  beat_t       exp_q[$];
  logic [7:0]  obs_frame[$];
  beat_t       mon_e;
  int          checks = 0;
  int          errors = 0;
  int          err_seen = 0;
  int          pay_rdy_seen = 0;
  int          frame_bytes = 0;
  int          err_exp = 0;
  int          tr_mode = 0;
  logic [15:0] ident_model = 16'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Reference frame: byte list from the header field definitions and ones' complement sum
  task automatic model_frame(input hdr_t h, input logic [7:0] pay[$], input logic tu);
    logic [7:0]  b[$];
    logic [15:0] eff;
    logic [15:0] tot;
    logic [15:0] ck;
    int unsigned s;
    eff = (h.len < 16'd8) ? 16'd8 : h.len;
    tot = eff + 16'd20;
    s = 32'h4500 + 32'(DSCP) * 4 + 32'(tot) + 32'(ident_model) + 32'h4000 + 32'(TTL) * 256 + 32'h11
        + 32'(h.sip[31:16]) + 32'(h.sip[15:0]) + 32'(h.dip[31:16]) + 32'(h.dip[15:0]);
    while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
    ck = ~16'(s);
    for (int i = 5; i >= 0; i--) b.push_back(h.dmac[i*8 +: 8]);
    for (int i = 5; i >= 0; i--) b.push_back(h.smac[i*8 +: 8]);
    b.push_back(8'h08); b.push_back(8'h00);
    b.push_back(8'h45); b.push_back({DSCP, 2'b00});
    b.push_back(tot[15:8]); b.push_back(tot[7:0]);
    b.push_back(ident_model[15:8]); b.push_back(ident_model[7:0]);
    b.push_back(8'h40); b.push_back(8'h00);
    b.push_back(TTL); b.push_back(8'h11);
    b.push_back(ck[15:8]); b.push_back(ck[7:0]);
    for (int i = 3; i >= 0; i--) b.push_back(h.sip[i*8 +: 8]);
    for (int i = 3; i >= 0; i--) b.push_back(h.dip[i*8 +: 8]);
    b.push_back(h.sport[15:8]); b.push_back(h.sport[7:0]);
    b.push_back(h.dport[15:8]); b.push_back(h.dport[7:0]);
    b.push_back(eff[15:8]); b.push_back(eff[7:0]);
    b.push_back(8'h00); b.push_back(8'h00);
    for (int i = 0; i < b.size(); i++)
      exp_q.push_back('{d: b[i], l: (eff == 16'd8) && (i == b.size() - 1), u: 1'b0});
    for (int i = 0; i < pay.size(); i++)
      exp_q.push_back('{d: pay[i], l: (i == pay.size() - 1),
                        u: (i == pay.size() - 1) && (tu || (pay.size() != int'(eff) - 8))});
    err_exp = ((h.len < 16'd8) ? 1 : 0) + (((eff > 16'd8) && (pay.size() != int'(eff) - 8)) ? 1 : 0);
    ident_model = ident_model + 16'd1;
  endtask

  // Monitor: every beat transferred on the frame stream is checked against the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (ifc.error_payload_length) err_seen++;
      if (ifc.s_udp_payload_axis_tready) pay_rdy_seen++;
      if (ifc.m_axis_tvalid && ifc.m_axis_tready) begin
        frame_bytes++;
        obs_frame.push_back(ifc.m_axis_tdata);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: actual d=0x%0h with no beat required", ifc.m_axis_tdata);
        end else begin
          mon_e = exp_q.pop_front();
          check($sformatf("beat%0d", frame_bytes - 1),
                32'({ifc.m_axis_tlast, ifc.m_axis_tuser, ifc.m_axis_tdata}),
                32'({mon_e.l, mon_e.u, mon_e.d}));
        end
      end
    end
  end

  // Downstream ready pattern: 0 always ready, 1 toggling, 2 random
  initial begin
    ifc.m_axis_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (tr_mode)
        0:       ifc.m_axis_tready = 1'b1;
        1:       ifc.m_axis_tready = ~ifc.m_axis_tready;
        default: ifc.m_axis_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic drive_hdr(input hdr_t h);
    logic rdy;
    logic done;
    done = 1'b0;
    ifc.s_eth_dest_mac    = h.dmac;
    ifc.s_eth_src_mac     = h.smac;
    ifc.s_ip_source_ip    = h.sip;
    ifc.s_ip_dest_ip      = h.dip;
    ifc.s_udp_source_port = h.sport;
    ifc.s_udp_dest_port   = h.dport;
    ifc.s_udp_length      = h.len;
    ifc.s_udp_hdr_valid   = 1'b1;
    for (int i = 0; i < 500 && !done; i++) begin
      @(negedge clk);
      rdy = ifc.s_udp_hdr_ready;
      @(posedge clk);
      #1;
      done = rdy;
    end
    ifc.s_udp_hdr_valid = 1'b0;
    if (!done) check("hdr_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drive_pay(input logic [7:0] pay[$], input logic tu);
    logic hs;
    for (int k = 0; k < pay.size(); k++) begin
      if ($urandom_range(0, 3) == 0) begin
        ifc.s_udp_payload_axis_tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      ifc.s_udp_payload_axis_tdata  = pay[k];
      ifc.s_udp_payload_axis_tlast  = (k == pay.size() - 1);
      ifc.s_udp_payload_axis_tuser  = (k == pay.size() - 1) ? tu : 1'b0;
      ifc.s_udp_payload_axis_tvalid = 1'b1;
      hs = 1'b0;
      for (int i = 0; i < 2000 && !hs; i++) begin
        @(negedge clk);
        hs = ifc.s_udp_payload_axis_tvalid && ifc.s_udp_payload_axis_tready;
        @(posedge clk);
        #1;
      end
      if (!hs) begin
        check("payload_timeout", 32'd0, 32'd1);
        break;
      end
    end
    ifc.s_udp_payload_axis_tvalid = 1'b0;
    ifc.s_udp_payload_axis_tlast  = 1'b0;
    ifc.s_udp_payload_axis_tuser  = 1'b0;
  endtask

  task automatic run_frame(input hdr_t h, input int n_pay, input logic tu);
    logic [7:0] pay[$];
    for (int i = 0; i < n_pay; i++) pay.push_back(8'($urandom));
    obs_frame.delete();
    err_seen     = 0;
    pay_rdy_seen = 0;
    frame_bytes  = 0;
    model_frame(h, pay, tu);
    fork
      drive_hdr(h);
      begin
        if (n_pay > 0) drive_pay(pay, tu);
      end
    join
    for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
    check("frame_len", 32'(obs_frame.size()), 32'(42 + n_pay));
    check("err_pulses", 32'(err_seen), 32'(err_exp));
    if (n_pay == 0) check("pay_tready_idle", 32'(pay_rdy_seen), 32'd0);
  endtask

  hdr_t h;
  hdr_t hr;

  initial begin
    rst_n = 1'b0;
    ifc.s_udp_hdr_valid           = 1'b0;
    ifc.s_eth_dest_mac            = '0;
    ifc.s_eth_src_mac             = '0;
    ifc.s_ip_source_ip            = '0;
    ifc.s_ip_dest_ip              = '0;
    ifc.s_udp_source_port         = '0;
    ifc.s_udp_dest_port           = '0;
    ifc.s_udp_length              = '0;
    ifc.s_udp_payload_axis_tdata  = '0;
    ifc.s_udp_payload_axis_tvalid = 1'b0;
    ifc.s_udp_payload_axis_tlast  = 1'b0;
    ifc.s_udp_payload_axis_tuser  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_hdr_ready", 32'(ifc.s_udp_hdr_ready), 32'd1);
    check("rst_tvalid", 32'(ifc.m_axis_tvalid), 32'd0);
    check("rst_busy", 32'(ifc.busy), 32'd0);
    check("rst_pay_tready", 32'(ifc.s_udp_payload_axis_tready), 32'd0);
    check("rst_err", 32'(ifc.error_payload_length), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reference frame with 8 payload bytes
    h = '{dmac: 48'h001122334455, smac: 48'h0A0B0C0D0E0F, sip: 32'hC0A80164, dip: 32'hC0A80101,
          sport: 16'd1234, dport: 16'd5678, len: 16'd16};
    tr_mode = 0;
    run_frame(h, 8, 1'b0);
    check("t1_total_len", 32'({obs_frame[16], obs_frame[17]}), 32'h0024);
    check("t1_checksum", 32'({obs_frame[24], obs_frame[25]}), 32'hB713);

    // Same frame under a toggling ready
    tr_mode = 1;
    run_frame(h, 8, 1'b0);
    check("t2_ident", 32'({obs_frame[18], obs_frame[19]}), 32'h0001);

    // Header-only frame
    tr_mode = 0;
    h.len = 16'd8;
    run_frame(h, 0, 1'b0);

    // Early payload tlast
    h.len = 16'd16;
    run_frame(h, 5, 1'b0);

    // Undersized UDP length
    h.len = 16'd4;
    run_frame(h, 0, 1'b0);
    check("t5_total_len", 32'({obs_frame[16], obs_frame[17]}), 32'h001C);
    check("t5_udp_len", 32'({obs_frame[38], obs_frame[39]}), 32'h0008);

    // Randomized frames
    for (int f = 0; f < 14; f++) begin
      int n;
      hr.dmac  = 48'({$urandom, $urandom});
      hr.smac  = 48'({$urandom, $urandom});
      hr.sip   = $urandom;
      hr.dip   = $urandom;
      hr.sport = 16'($urandom);
      hr.dport = 16'($urandom);
      n = $urandom_range(0, 20);
      hr.len = 16'(n + 8);
      if ($urandom_range(0, 5) == 0) begin
        hr.len = 16'($urandom_range(0, 7));
        n = 0;
      end else if (n > 0 && $urandom_range(0, 3) == 0) begin
        n = $urandom_range(1, n + 3);
      end
      tr_mode = $urandom_range(0, 2);
      run_frame(hr, n, 1'($urandom_range(0, 3) == 0));
    end

    // Asynchronous reset while byte 20 is on the bus
    tr_mode = 0;
    h.len = 16'd8;
    obs_frame.delete();
    frame_bytes = 0;
    model_frame(h, obs_frame, 1'b0);
    drive_hdr(h);
    for (int i = 0; i < 200 && frame_bytes < 20; i++) begin
      @(posedge clk);
      #2;
    end
    check("t6_bytes_before_reset", 32'(frame_bytes), 32'd20);
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    check("t6_tvalid_now", 32'(ifc.m_axis_tvalid), 32'd0);
    check("t6_busy_now", 32'(ifc.busy), 32'd0);
    @(negedge clk);
    check("t6_tvalid_edge", 32'(ifc.m_axis_tvalid), 32'd0);
    check("t6_hdr_ready", 32'(ifc.s_udp_hdr_ready), 32'd1);
    ident_model = 16'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    h.len = 16'd12;
    run_frame(h, 4, 1'b0);
    check("t6_ident_after_reset", 32'({obs_frame[18], obs_frame[19]}), 32'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
